// File: rtl/guess_judge.sv
// guess_judge: judges a multi-digit BCD guess against a secret answer, MSB digit first,
// with button edge detection, invalid-digit rejection, an attempt budget and WON/LOST states.
module guess_judge #(
   parameter int unsigned NUM_DIGITS = 3,
   parameter int unsigned DIGIT_W    = 4,
   parameter int unsigned MAX_TRIES  = 7,
   parameter int unsigned TRY_W      = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          confirm_btn,
   input  logic                          new_game,
   input  logic [NUM_DIGITS*DIGIT_W-1:0] key,
   input  logic [NUM_DIGITS*DIGIT_W-1:0] answer,
   output logic [1:0]                    hint,
   output logic                          hint_valid,
   output logic [TRY_W-1:0]              tries_left,
   output logic                          busy,
   output logic                          win,
   output logic                          lose
);

   localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int unsigned KEY_W = NUM_DIGITS * DIGIT_W;

   localparam logic [1:0] HintHigh    = 2'd0;
   localparam logic [1:0] HintLow     = 2'd1;
   localparam logic [1:0] HintInvalid = 2'd2;
   localparam logic [1:0] HintBlank   = 2'd3;

   typedef enum logic [2:0] {StPlay, StCapture, StCmp, StWon, StLost} state_e;

   state_e             state_q, state_d;
   logic               btn_q;
   logic               press;
   logic [KEY_W-1:0]   key_q, key_d;
   logic [KEY_W-1:0]   ans_q, ans_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [1:0]         hint_q, hint_d;
   logic               hint_valid_q, hint_valid_d;
   logic [TRY_W-1:0]   tries_q, tries_d;
   logic [TRY_W-1:0]   tries_dec;
   logic               key_bad;
   logic [DIGIT_W-1:0] cur_key, cur_ans;

   assign press     = confirm_btn & ~btn_q;
   assign tries_dec = tries_q - TRY_W'(1);
   assign cur_key   = key_q[int'(idx_q)*DIGIT_W +: DIGIT_W];
   assign cur_ans   = ans_q[int'(idx_q)*DIGIT_W +: DIGIT_W];

   always_comb begin
      key_bad = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (32'(key_q[i*DIGIT_W +: DIGIT_W]) > 32'd9) key_bad = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StPlay;
         btn_q        <= 1'b0;
         key_q        <= '0;
         ans_q        <= '0;
         idx_q        <= '0;
         hint_q       <= HintBlank;
         hint_valid_q <= 1'b0;
         tries_q      <= TRY_W'(MAX_TRIES);
      end else begin
         state_q      <= state_d;
         btn_q        <= confirm_btn;
         key_q        <= key_d;
         ans_q        <= ans_d;
         idx_q        <= idx_d;
         hint_q       <= hint_d;
         hint_valid_q <= hint_valid_d;
         tries_q      <= tries_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      key_d        = key_q;
      ans_d        = ans_q;
      idx_d        = idx_q;
      hint_d       = hint_q;
      hint_valid_d = 1'b0;
      tries_d      = tries_q;
      if (new_game) begin
         // Restart wins over any judgement in flight; a same-cycle press is dropped.
         state_d = StPlay;
         tries_d = TRY_W'(MAX_TRIES);
         hint_d  = HintBlank;
      end else begin
         unique case (state_q)
            StPlay: begin
               if (press) begin
                  key_d   = key;
                  ans_d   = answer;
                  state_d = StCapture;
               end
            end
            StCapture: begin
               if (key_bad) begin
                  hint_d       = HintInvalid;
                  hint_valid_d = 1'b1;
                  state_d      = StPlay;
               end else begin
                  idx_d   = IDX_W'(NUM_DIGITS - 1);
                  state_d = StCmp;
               end
            end
            StCmp: begin
               if (cur_key != cur_ans) begin
                  hint_d       = (cur_key > cur_ans) ? HintHigh : HintLow;
                  hint_valid_d = 1'b1;
                  tries_d      = tries_dec;
                  state_d      = (tries_dec == '0) ? StLost : StPlay;
               end else if (idx_q != '0) begin
                  idx_d = idx_q - IDX_W'(1);
               end else begin
                  hint_d       = HintBlank;
                  hint_valid_d = 1'b1;
                  state_d      = StWon;
               end
            end
            StWon, StLost: ;
            default: state_d = StPlay;
         endcase
      end
   end

   always_comb begin
      hint       = hint_q;
      hint_valid = hint_valid_q;
      tries_left = tries_q;
      busy       = (state_q == StCapture) || (state_q == StCmp);
      win        = (state_q == StWon);
      lose       = (state_q == StLost);
   end

endmodule

// File: tb/tb_guess_judge.sv
// tb_guess_judge: randomized + directed stimulus, numeric reference model, queue scoreboard.
module tb_guess_judge;

   localparam int unsigned ND = 3;
   localparam int unsigned DW = 4;
   localparam int unsigned MT = 7;
   localparam int unsigned TW = 4;
   localparam int unsigned KW = ND * DW;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          confirm_btn = 1'b0;
   logic          new_game = 1'b0;
   logic [KW-1:0] key = '0;
   logic [KW-1:0] answer = '0;
   logic [1:0]    dut_hint;
   logic          dut_hint_valid;
   logic [TW-1:0] tries_left;
   logic          busy, win, lose;

   guess_judge #(
      .NUM_DIGITS(ND),
      .DIGIT_W   (DW),
      .MAX_TRIES (MT),
      .TRY_W     (TW)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .confirm_btn(confirm_btn),
      .new_game   (new_game),
      .key        (key),
      .answer     (answer),
      .hint       (dut_hint),
      .hint_valid (dut_hint_valid),
      .tries_left (tries_left),
      .busy       (busy),
      .win        (win),
      .lose       (lose)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int hint;
      int tries;
      int win;
      int lose;
      int due;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   failures = 0;

   // Model: 0 = playing, 1 = won, 2 = lost.
   int   m_state = 0;
   int   m_tries = MT;
   int   m_due = 0;
   bit   m_btn_prev = 1'b0;

   function automatic void chk(string name, int act, int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
      end
   endfunction

   function automatic logic [KW-1:0] bcd(int d2, int d1, int d0);
      logic [DW-1:0] a, b, c;
      a = DW'(d2);
      b = DW'(d1);
      c = DW'(d0);
      return {a, b, c};
   endfunction

   function automatic int digit(logic [KW-1:0] v, int i);
      logic [DW-1:0] d;
      d = v[i*DW +: DW];
      return int'(d);
   endfunction

   // Judge a captured guess by number value; leading-match count sets the latency.
   function automatic void model_judge(logic [KW-1:0] k, logic [KW-1:0] a, int edge_n);
      exp_t e;
      int   kn = 0, an = 0, lead = 0;
      bit   bad = 1'b0, stop = 1'b0;
      for (int i = ND - 1; i >= 0; i--) begin
         if (digit(k, i) > 9) bad = 1'b1;
         kn = kn * 10 + digit(k, i);
         an = an * 10 + digit(a, i);
         if (!stop && digit(k, i) == digit(a, i)) lead++;
         else stop = 1'b1;
      end
      e.win  = 0;
      e.lose = 0;
      if (bad) begin
         e.hint = 2;
         e.due  = edge_n + 1;
      end else if (kn == an) begin
         e.hint  = 3;
         e.due   = edge_n + 2 + ND - 1;
         e.win   = 1;
         m_state = 1;
      end else begin
         e.hint = (kn > an) ? 0 : 1;
         e.due  = edge_n + 2 + lead;
         m_tries--;
         if (m_tries == 0) begin
            e.lose  = 1;
            m_state = 2;
         end
      end
      e.tries = m_tries;
      m_due   = e.due;
      exp_q.push_back(e);
   endfunction

   task automatic drive(logic [KW-1:0] k, logic [KW-1:0] a, logic btn);
      int edge_n;
      @(negedge clk);
      key         = k;
      answer      = a;
      confirm_btn = btn;
      edge_n      = cyc + 1;
      if (btn && !m_btn_prev && m_state == 0 && edge_n > m_due) model_judge(k, a, edge_n);
      m_btn_prev = btn;
   endtask

   task automatic press(logic [KW-1:0] k, logic [KW-1:0] a);
      drive(k, a, 1'b1);
      drive(k, a, 1'b0);
   endtask

   task automatic idle(int n);
      repeat (n) begin
         @(negedge clk);
         confirm_btn = 1'b0;
         m_btn_prev  = 1'b0;
      end
   endtask

   task automatic do_new_game();
      @(negedge clk);
      new_game    = 1'b1;
      confirm_btn = 1'b0;
      m_btn_prev  = 1'b0;
      @(negedge clk);
      new_game = 1'b0;
      m_state  = 0;
      m_tries  = MT;
      m_due    = 0;
   endtask

   task automatic chk_idle_state(string tag, int tries);
      chk({tag, "_hint"}, int'(dut_hint), 3);
      chk({tag, "_hint_valid"}, int'(dut_hint_valid), 0);
      chk({tag, "_tries"}, int'(tries_left), tries);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_win"}, int'(win), 0);
      chk({tag, "_lose"}, int'(lose), 0);
   endtask

   // Scoreboard monitor, sampling on the inactive edge.
   always @(negedge clk) begin
      if (dut_hint_valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_hint_valid actual=1 required=0 (cycle %0d)", cyc);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("sb_hint", int'(dut_hint), e.hint);
            chk("sb_tries", int'(tries_left), e.tries);
            chk("sb_cycle", cyc, e.due);
            chk("sb_win", int'(win), e.win);
            chk("sb_lose", int'(lose), e.lose);
         end
      end else if (exp_q.size() > 0 && cyc > exp_q[0].due) begin
         checks++;
         failures++;
         $display("FAIL sb_timeout actual=no_pulse required=pulse_at_%0d (cycle %0d)",
                  exp_q[0].due, cyc);
         void'(exp_q.pop_front());
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [KW-1:0] k, a;
      int            r, p;

      repeat (3) @(negedge clk);
      chk_idle_state("reset_low", MT);
      rst_n = 1'b1;
      @(negedge clk);
      chk_idle_state("reset_rel", MT);

      // Guess too high on the first digit.
      press(bcd(5, 0, 0), bcd(4, 7, 2));
      idle(6);
      chk("t1_busy_after", int'(busy), 0);
      chk("t1_tries", int'(tries_left), 6);

      do_new_game();
      press(bcd(4, 7, 1), bcd(4, 7, 2));
      idle(6);
      chk("t2_tries", int'(tries_left), 6);
      press(bcd(4, 7, 2), bcd(4, 7, 2));
      idle(6);
      chk("t2_win", int'(win), 1);
      chk("t2_busy", int'(busy), 0);
      press(bcd(1, 1, 1), bcd(4, 7, 2));
      idle(6);
      chk("t2_win_sticky", int'(win), 1);

      // Invalid digit: no try consumed.
      do_new_game();
      press(bcd(4, 10, 2), bcd(4, 7, 2));
      idle(4);
      chk("t3_tries", int'(tries_left), MT);
      chk("t3_busy", int'(busy), 0);
      chk("t3_hint", int'(dut_hint), 2);

      // Exhaust the budget.
      do_new_game();
      for (int i = 0; i < int'(MT); i++) begin
         chk("t4_tries_before", int'(tries_left), int'(MT) - i);
         press(bcd(9, 9, 9), bcd(4, 7, 2));
         idle(5);
      end
      chk("t4_lose", int'(lose), 1);
      chk("t4_tries_zero", int'(tries_left), 0);
      press(bcd(4, 7, 2), bcd(4, 7, 2));
      idle(6);
      chk("t4_lose_sticky", int'(lose), 1);

      // Held button gives one judgement; a press while busy is ignored.
      do_new_game();
      repeat (21) drive(bcd(1, 2, 3), bcd(4, 7, 2), 1'b1);
      drive(bcd(1, 2, 3), bcd(4, 7, 2), 1'b0);
      idle(4);
      chk("t5_tries_held", int'(tries_left), 6);
      press(bcd(4, 7, 0), bcd(4, 7, 2));
      press(bcd(4, 7, 2), bcd(4, 7, 2));
      idle(6);
      chk("t5_tries_busy", int'(tries_left), 5);
      chk("t5_no_win", int'(win), 0);

      // new_game mid-CMP aborts without a pulse.
      do_new_game();
      press(bcd(4, 7, 0), bcd(4, 7, 9));
      void'(exp_q.pop_back());
      do_new_game();
      chk_idle_state("t6_ng", MT);
      idle(6);

      // Asynchronous reset mid-CMP.
      press(bcd(8, 0, 0), bcd(4, 7, 9));
      idle(5);
      press(bcd(4, 7, 0), bcd(4, 7, 9));
      void'(exp_q.pop_back());
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk_idle_state("t7_rst", MT);
      @(negedge clk);
      rst_n      = 1'b1;
      m_state    = 0;
      m_tries    = MT;
      m_due      = 0;
      m_btn_prev = 1'b0;
      idle(6);

      // Randomized games.
      for (int it = 0; it < 80; it++) begin
         if (m_state != 0) do_new_game();
         a = bcd($urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9));
         r = $urandom_range(0, 9);
         k = bcd($urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9));
         if (r == 0) begin
            k = a;
         end else if (r == 1) begin
            p = $urandom_range(0, ND - 1);
            k = a;
            k[p*DW +: DW] = DW'($urandom_range(10, 15));
         end else if (r <= 4) begin
            p = $urandom_range(0, ND - 1);
            k = a;
            k[p*DW +: DW] = DW'($urandom_range(0, 9));
         end
         press(k, a);
         if ($urandom_range(0, 3) == 0) begin
            drive(KW'($urandom), KW'($urandom), 1'b1);
            drive(KW'($urandom), KW'($urandom), 1'b0);
         end
         idle(ND + 6);
      end

      idle(5);
      chk("pending_expectations", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
